// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle core main controller: states, opcodes,
// ALU-op classes, datapath mux selects and the packed control word.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_WB_R     = 4'd4,
    S_WB_I     = 4'd5,
    S_LHI_WB   = 4'd6,
    S_MEM_ADDR = 4'd7,
    S_MEM_RD   = 4'd8,
    S_MEM_WB   = 4'd9,
    S_MEM_WR   = 4'd10,
    S_BEQ_CMP  = 4'd11,
    S_JAL_ST   = 4'd12,
    S_JLR_ST   = 4'd13,
    S_HALT     = 4'd14
  } state_t;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_ADI = 4'b0001;
  localparam logic [3:0] OP_NDU = 4'b0010;
  localparam logic [3:0] OP_LHI = 4'b0011;
  localparam logic [3:0] OP_LW  = 4'b0100;
  localparam logic [3:0] OP_SW  = 4'b0101;
  localparam logic [3:0] OP_JAL = 4'b1000;
  localparam logic [3:0] OP_JLR = 4'b1001;
  localparam logic [3:0] OP_BEQ = 4'b1100;

  localparam logic [1:0] ALUOP_ADDF  = 2'b00;
  localparam logic [1:0] ALUOP_ADD   = 2'b01;
  localparam logic [1:0] ALUOP_NANDF = 2'b10;
  localparam logic [1:0] ALUOP_SUB   = 2'b11;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM6 = 2'b10;
  localparam logic [1:0] SRCB_IMM9 = 2'b11;

  localparam logic [1:0] RDST_IR5_3  = 2'b00;
  localparam logic [1:0] RDST_IR8_6  = 2'b01;
  localparam logic [1:0] RDST_IR11_9 = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;
  localparam logic [1:0] M2R_LHI    = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_REGA   = 2'b10;

  localparam logic [1:0] CZ_CARRY = 2'b10;
  localparam logic [1:0] CZ_ZERO  = 2'b01;

  typedef struct packed {
    logic       pcwrite;
    logic       irwrite;
    logic       regwrite;
    logic       flagwrite;
    logic       memread;
    logic       memwrite;
    logic       iord;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
  } ctrl_t;

  // Undefined opcodes land in HALT; the caller uses that to set the sticky flag.
  function automatic state_t dispatch_state(input logic [3:0] op);
    case (op)
      OP_ADD, OP_NDU: dispatch_state = S_EXEC_R;
      OP_ADI:         dispatch_state = S_EXEC_I;
      OP_LHI:         dispatch_state = S_LHI_WB;
      OP_LW, OP_SW:   dispatch_state = S_MEM_ADDR;
      OP_BEQ:         dispatch_state = S_BEQ_CMP;
      OP_JAL:         dispatch_state = S_JAL_ST;
      OP_JLR:         dispatch_state = S_JLR_ST;
      default:        dispatch_state = S_HALT;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// State to control-word decoder. Enables that the top gates with mem_ready,
// alu_zero or the flag condition are emitted here as their ungated value.
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  state_t     i_state,
  input  logic [3:0] i_opcode,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.memread = 1'b1;
        o_ctrl.pcwrite = 1'b1;
        o_ctrl.irwrite = 1'b1;
        o_ctrl.alusrcb = SRCB_ONE;
        o_ctrl.aluop   = ALUOP_ADD;
      end
      S_DECODE: begin
        // JAL branches by imm9, everything else precomputes PC+imm6.
        o_ctrl.alusrcb = (i_opcode == OP_JAL) ? SRCB_IMM9 : SRCB_IMM6;
        o_ctrl.aluop   = ALUOP_ADD;
      end
      S_EXEC_R: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = SRCB_REGB;
        o_ctrl.aluop   = (i_opcode == OP_NDU) ? ALUOP_NANDF : ALUOP_ADDF;
      end
      S_WB_R: begin
        o_ctrl.regdst    = RDST_IR5_3;
        o_ctrl.memtoreg  = M2R_ALUOUT;
        o_ctrl.regwrite  = 1'b1;
        o_ctrl.flagwrite = 1'b1;
      end
      S_EXEC_I: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = SRCB_IMM6;
        o_ctrl.aluop   = ALUOP_ADD;
      end
      S_WB_I: begin
        o_ctrl.regdst    = RDST_IR8_6;
        o_ctrl.memtoreg  = M2R_ALUOUT;
        o_ctrl.regwrite  = 1'b1;
        o_ctrl.flagwrite = 1'b1;
      end
      S_LHI_WB: begin
        o_ctrl.regdst   = RDST_IR11_9;
        o_ctrl.memtoreg = M2R_LHI;
        o_ctrl.regwrite = 1'b1;
      end
      S_MEM_ADDR: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = SRCB_IMM6;
        o_ctrl.aluop   = ALUOP_ADD;
      end
      S_MEM_RD: begin
        o_ctrl.iord    = 1'b1;
        o_ctrl.memread = 1'b1;
      end
      S_MEM_WB: begin
        o_ctrl.regdst    = RDST_IR11_9;
        o_ctrl.memtoreg  = M2R_MDR;
        o_ctrl.regwrite  = 1'b1;
        o_ctrl.flagwrite = 1'b1;
      end
      S_MEM_WR: begin
        o_ctrl.iord     = 1'b1;
        o_ctrl.memwrite = 1'b1;
      end
      S_BEQ_CMP: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = SRCB_REGB;
        o_ctrl.aluop   = ALUOP_SUB;
        o_ctrl.pcsrc   = PCSRC_ALUOUT;
        o_ctrl.pcwrite = 1'b1;
      end
      S_JAL_ST: begin
        o_ctrl.regdst   = RDST_IR11_9;
        o_ctrl.memtoreg = M2R_PC;
        o_ctrl.regwrite = 1'b1;
        o_ctrl.pcsrc    = PCSRC_ALUOUT;
        o_ctrl.pcwrite  = 1'b1;
      end
      S_JLR_ST: begin
        o_ctrl.regdst   = RDST_IR11_9;
        o_ctrl.memtoreg = M2R_PC;
        o_ctrl.regwrite = 1'b1;
        o_ctrl.pcsrc    = PCSRC_REGA;
        o_ctrl.pcwrite  = 1'b1;
      end
      S_HALT:  o_ctrl = '0;
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_main_ctrl.sv
// Main control FSM of the multicycle 16-bit core: state register, next-state
// dispatch, and the mem_ready / alu_zero / flag gating of the decoded word.
module mc_main_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] opcode,
  input  logic [1:0] cz,
  input  logic       carry_flag,
  input  logic       zero_flag,
  input  logic       mem_ready,
  input  logic       alu_zero,
  output logic       pcwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       flagwrite,
  output logic       memread,
  output logic       memwrite,
  output logic       iord,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] regdst,
  output logic [1:0] memtoreg,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic [1:0] cz_out,
  output logic       illegal,
  output logic [3:0] dbg_state
);

  // Memory handshake: the memory side holds mem_ready=1 for exactly the cycle
  // in which it completes the access requested by memread/memwrite; the FSM
  // samples it on that cycle's rising edge and commits IR/PC in the same cycle.

  state_t r_state;
  state_t w_next;
  logic   r_run;
  logic   r_illegal;
  ctrl_t  w_base;
  logic   w_cond;
  logic   w_gate_fetch;
  logic   w_gate_wb;
  logic   w_gate_beq;

  mc_ctrl_outdec u_outdec (
    .i_state  (r_state),
    .i_opcode (opcode),
    .o_ctrl   (w_base)
  );

  always_comb begin
    case (cz)
      CZ_CARRY: w_cond = carry_flag;
      CZ_ZERO:  w_cond = zero_flag;
      default:  w_cond = 1'b1;
    endcase
  end

  assign w_gate_fetch = (r_state == S_FETCH)   ? mem_ready : 1'b1;
  assign w_gate_wb    = (r_state == S_WB_R)    ? w_cond    : 1'b1;
  assign w_gate_beq   = (r_state == S_BEQ_CMP) ? alu_zero  : 1'b1;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:    if (mem_ready) w_next = S_DECODE;
      S_DECODE:   w_next = dispatch_state(opcode);
      S_EXEC_R:   w_next = S_WB_R;
      S_EXEC_I:   w_next = S_WB_I;
      S_MEM_ADDR: w_next = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) w_next = S_MEM_WB;
      S_MEM_WR:   if (mem_ready) w_next = S_FETCH;
      S_WB_R, S_WB_I, S_LHI_WB, S_MEM_WB,
      S_BEQ_CMP, S_JAL_ST, S_JLR_ST: w_next = S_FETCH;
      S_HALT:     w_next = S_HALT;
      default:    w_next = S_FETCH;
    endcase
  end

  // r_run delays the first FETCH outputs to the cycle after reset release and
  // clears asynchronously, so every enable drops the instant reset asserts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_run     <= 1'b0;
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (r_run) begin
        r_state <= w_next;
        if (r_state == S_DECODE && w_next == S_HALT) r_illegal <= 1'b1;
      end
    end
  end

  assign pcwrite   = r_run & w_base.pcwrite & w_gate_fetch & w_gate_beq;
  assign irwrite   = r_run & w_base.irwrite & w_gate_fetch;
  assign regwrite  = r_run & w_base.regwrite & w_gate_wb;
  assign flagwrite = r_run & w_base.flagwrite & w_gate_wb;
  assign memread   = r_run & w_base.memread;
  assign memwrite  = r_run & w_base.memwrite;
  assign iord      = r_run & w_base.iord;
  assign alusrca   = r_run & w_base.alusrca;
  assign alusrcb   = {2{r_run}} & w_base.alusrcb;
  assign regdst    = {2{r_run}} & w_base.regdst;
  assign memtoreg  = {2{r_run}} & w_base.memtoreg;
  assign pcsrc     = {2{r_run}} & w_base.pcsrc;
  assign aluop     = {2{r_run}} & w_base.aluop;
  assign cz_out    = cz;
  assign illegal   = r_illegal;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Self-checking bench for mc_main_ctrl: each instruction is expanded into its
// expected per-cycle state list, and every cycle's control word is checked.
module tb_mc_main_ctrl;
  import mc_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] opcode;
  logic [1:0] cz;
  logic       carry_flag, zero_flag, mem_ready, alu_zero;
  logic       pcwrite, irwrite, regwrite, flagwrite, memread, memwrite, iord, alusrca;
  logic [1:0] alusrcb, regdst, memtoreg, pcsrc, aluop, cz_out;
  logic       illegal;
  logic [3:0] dbg_state;

  int total = 0;
  int bad   = 0;

  mc_main_ctrl dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .cz(cz),
    .carry_flag(carry_flag), .zero_flag(zero_flag), .mem_ready(mem_ready),
    .alu_zero(alu_zero), .pcwrite(pcwrite), .irwrite(irwrite),
    .regwrite(regwrite), .flagwrite(flagwrite), .memread(memread),
    .memwrite(memwrite), .iord(iord), .alusrca(alusrca), .alusrcb(alusrcb),
    .regdst(regdst), .memtoreg(memtoreg), .pcsrc(pcsrc), .aluop(aluop),
    .cz_out(cz_out), .illegal(illegal), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [17:0] obs_word;
  assign obs_word = {pcwrite, irwrite, regwrite, flagwrite, memread, memwrite,
                     iord, alusrca, alusrcb, regdst, memtoreg, pcsrc, aluop};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected control word, written from the per-state output table.
  function automatic logic [17:0] exp_word(input state_t s, input logic [3:0] op,
                                           input logic [1:0] czv, input logic cf,
                                           input logic zf, input logic mr, input logic az);
    logic pcw, irw, rgw, flw, mrd, mwr, ird, sra;
    logic [1:0] srb, rdst, m2r, psrc, aop;
    logic cnd;
    {pcw, irw, rgw, flw, mrd, mwr, ird, sra} = '0;
    {srb, rdst, m2r, psrc, aop} = '0;
    cnd = (czv == 2'b10) ? cf : (czv == 2'b01) ? zf : 1'b1;
    case (s)
      S_FETCH:    begin mrd = 1; srb = 2'b01; aop = 2'b01; irw = mr; pcw = mr; end
      S_DECODE:   begin srb = (op == 4'b1000) ? 2'b11 : 2'b10; aop = 2'b01; end
      S_EXEC_R:   begin sra = 1; srb = 2'b00; aop = (op == 4'b0010) ? 2'b10 : 2'b00; end
      S_WB_R:     begin rgw = cnd; flw = cnd; end
      S_EXEC_I:   begin sra = 1; srb = 2'b10; aop = 2'b01; end
      S_WB_I:     begin rdst = 2'b01; rgw = 1; flw = 1; end
      S_LHI_WB:   begin rdst = 2'b10; m2r = 2'b11; rgw = 1; end
      S_MEM_ADDR: begin sra = 1; srb = 2'b10; aop = 2'b01; end
      S_MEM_RD:   begin ird = 1; mrd = 1; end
      S_MEM_WB:   begin rdst = 2'b10; m2r = 2'b01; rgw = 1; flw = 1; end
      S_MEM_WR:   begin ird = 1; mwr = 1; end
      S_BEQ_CMP:  begin aop = 2'b11; sra = 1; psrc = 2'b01; pcw = az; end
      S_JAL_ST:   begin rdst = 2'b10; m2r = 2'b10; rgw = 1; psrc = 2'b01; pcw = 1; end
      S_JLR_ST:   begin rdst = 2'b10; m2r = 2'b10; rgw = 1; psrc = 2'b10; pcw = 1; end
      default:    ;
    endcase
    return {pcw, irw, rgw, flw, mrd, mwr, ird, sra, srb, rdst, m2r, psrc, aop};
  endfunction

  task automatic do_reset();
    reset_n   = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_word", 32'(obs_word), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(S_FETCH));
    chk("rst_illegal", 32'(illegal), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rel_word", 32'(obs_word), 32'd0);
  endtask

  // Expands one instruction into its cycle list (fetch stalls sf, memory
  // stalls sm), drives it and checks every cycle. abort_at>=0 drops reset
  // just after that cycle has been checked.
  task automatic run_instr(input logic [3:0] op, input logic [1:0] czv,
                           input logic cf, input logic zf, input logic az,
                           input int sf, input int sm, input int abort_at);
    state_t sq[$];
    logic   mq[$];
    for (int k = 0; k < sf; k++) begin sq.push_back(S_FETCH); mq.push_back(1'b0); end
    sq.push_back(S_FETCH);  mq.push_back(1'b1);
    sq.push_back(S_DECODE); mq.push_back(1'($urandom));
    case (op)
      4'b0000, 4'b0010: begin
        sq.push_back(S_EXEC_R); mq.push_back(1'($urandom));
        sq.push_back(S_WB_R);   mq.push_back(1'($urandom));
      end
      4'b0001: begin
        sq.push_back(S_EXEC_I); mq.push_back(1'($urandom));
        sq.push_back(S_WB_I);   mq.push_back(1'($urandom));
      end
      4'b0011: begin sq.push_back(S_LHI_WB); mq.push_back(1'($urandom)); end
      4'b0100, 4'b0101: begin
        sq.push_back(S_MEM_ADDR); mq.push_back(1'($urandom));
        for (int k = 0; k < sm; k++) begin
          sq.push_back((op == 4'b0100) ? S_MEM_RD : S_MEM_WR); mq.push_back(1'b0);
        end
        sq.push_back((op == 4'b0100) ? S_MEM_RD : S_MEM_WR); mq.push_back(1'b1);
        if (op == 4'b0100) begin sq.push_back(S_MEM_WB); mq.push_back(1'($urandom)); end
      end
      4'b1100: begin sq.push_back(S_BEQ_CMP); mq.push_back(1'($urandom)); end
      4'b1000: begin sq.push_back(S_JAL_ST);  mq.push_back(1'($urandom)); end
      4'b1001: begin sq.push_back(S_JLR_ST);  mq.push_back(1'($urandom)); end
      default: for (int k = 0; k < 10; k++) begin sq.push_back(S_HALT); mq.push_back(1'($urandom)); end
    endcase
    for (int i = 0; i < sq.size(); i++) begin
      @(posedge clk);
      #1;
      opcode     = (sq[i] == S_FETCH) ? 4'($urandom) : op;
      mem_ready  = mq[i];
      cz         = czv;
      carry_flag = cf;
      zero_flag  = zf;
      alu_zero   = az;
      @(negedge clk);
      chk("state", 32'(dbg_state), 32'(sq[i]));
      chk("ctrl_word", 32'(obs_word), 32'(exp_word(sq[i], op, czv, cf, zf, mq[i], az)));
      chk("cz_out", 32'(cz_out), 32'(czv));
      chk("illegal", 32'(illegal), 32'(sq[i] == S_HALT));
      if (i == abort_at) begin
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort_memwrite", 32'(memwrite), 32'd0);
        chk("abort_word", 32'(obs_word), 32'd0);
        chk("abort_state", 32'(dbg_state), 32'(S_FETCH));
        return;
      end
    end
  endtask

  logic [3:0] legal_ops [9] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
                                4'b0101, 4'b1000, 4'b1001, 4'b1100};
  logic [3:0] bad_ops [7]   = '{4'b0110, 4'b0111, 4'b1010, 4'b1011, 4'b1101,
                                4'b1110, 4'b1111};

  initial begin
    reset_n = 1'b0; opcode = '0; cz = '0; carry_flag = 0; zero_flag = 0;
    mem_ready = 0; alu_zero = 0;
    do_reset();

    run_instr(4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 0, 0, -1);  // plain ADD
    run_instr(4'b0000, 2'b10, 1'b0, 1'b1, 1'b0, 0, 0, -1);  // ADC, carry clear
    run_instr(4'b0010, 2'b01, 1'b0, 1'b1, 1'b0, 0, 0, -1);  // NDZ, zero set
    run_instr(4'b0100, 2'b00, 1'b0, 1'b0, 1'b0, 0, 3, -1);  // LW, 3 stalls
    run_instr(4'b1100, 2'b00, 1'b0, 1'b0, 1'b1, 0, 0, -1);  // BEQ taken
    run_instr(4'b1100, 2'b00, 1'b0, 1'b0, 1'b0, 0, 0, -1);  // BEQ not taken
    run_instr(4'b1000, 2'b00, 1'b0, 1'b0, 1'b0, 2, 0, -1);  // JAL, fetch stall
    run_instr(4'b1001, 2'b00, 1'b0, 1'b0, 1'b0, 0, 0, -1);
    run_instr(4'b0011, 2'b00, 1'b0, 1'b0, 1'b0, 0, 0, -1);
    run_instr(4'b0001, 2'b11, 1'b0, 1'b0, 1'b0, 0, 0, -1);
    run_instr(4'b0101, 2'b00, 1'b0, 1'b0, 1'b0, 1, 2, -1);

    for (int n = 0; n < 60; n++) begin
      run_instr(legal_ops[$urandom_range(0, 8)], 2'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), $urandom_range(0, 2),
                $urandom_range(0, 3), -1);
    end

    run_instr(4'b1111, 2'b00, 1'b0, 1'b0, 1'b0, 0, 0, -1);  // HALT for 10 cycles
    do_reset();
    run_instr(bad_ops[$urandom_range(0, 6)], 2'($urandom), 1'b0, 1'b0, 1'b0, 1, 0, -1);
    do_reset();

    // SW stalled in MEM_WR: index 3 is the first MEM_WR cycle.
    run_instr(4'b0101, 2'b00, 1'b0, 1'b0, 1'b0, 0, 3, 3);
    do_reset();
    run_instr(4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 0, 0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
